// File: rtl/mul_hilo_ctrl.sv
// Multi-cycle multiply sequencer that owns the HI/LO register pair.
// Define MUL_ACC_EN to build the MADD/MSUB accumulate datapath.
module mul_hilo_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   input  logic [1:0]  hilo_we,
   input  logic [31:0] hilo_wdata,
   output logic        stall_o,
   output logic        done_o,
   output logic        mlu_start,
   output logic        mlu_sign,
   output logic [31:0] mlu_op1,
   output logic [31:0] mlu_op2,
   input  logic [63:0] mlu_result,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

   state_t      state;
   logic [2:0]  cnt;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        uns_q;
   logic [63:0] prod;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        start_q;
   logic        accept;
   logic        commit;
   logic [63:0] hilo_nxt;

   assign accept = req_valid & ~flush;
   assign commit = (state == WB) & ~flush;

`ifdef MUL_ACC_EN
   logic [1:0] acc_q;

   always_comb begin
      hilo_nxt = prod;
      case (acc_q)
         2'b01:   hilo_nxt = {hi, lo} + prod;
         2'b10:   hilo_nxt = {hi, lo} - prod;
         default: hilo_nxt = prod;
      endcase
   end
`else
   logic unused_op;

   assign unused_op = ^req_op[2:1];
   assign hilo_nxt  = prod;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         uns_q   <= 1'b0;
         prod    <= '0;
         start_q <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef MUL_ACC_EN
         acc_q   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q     <= req_a;
                  b_q     <= req_b;
                  uns_q   <= req_op[0];
`ifdef MUL_ACC_EN
                  acc_q   <= req_op[2:1];
`endif
                  cnt     <= CNT_INIT;
                  start_q <= 1'b1;
                  state   <= CALC;
               end
            end
            CALC: begin
               if (flush) begin
                  start_q <= 1'b0;
                  state   <= IDLE;
               end else if (cnt == 3'd0) begin
                  prod    <= mlu_result;
                  start_q <= 1'b0;
                  state   <= WB;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            WB:      state <= IDLE;
            default: state <= IDLE;
         endcase

         // A committing multiply is younger than any MTHI/MTLO
         if (commit) begin
            {hi, lo} <= hilo_nxt;
         end else begin
            if (hilo_we[1]) hi <= hilo_wdata;
            if (hilo_we[0]) lo <= hilo_wdata;
         end
      end
   end

   assign stall_o   = ((state == IDLE) & accept) | (state == CALC);
   assign done_o    = commit;
   assign mlu_start = start_q;
   assign mlu_sign  = ~uns_q;
   assign mlu_op1   = a_q;
   assign mlu_op2   = b_q;
   assign hi_o      = hi;
   assign lo_o      = lo;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Randomised bench for mul_hilo_ctrl against an arithmetic HI/LO model.
// Honours MUL_ACC_EN the same way as the design.
module tb_mul_hilo_ctrl;

   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        flush = 1'b0;
   logic [1:0]  hilo_we = '0;
   logic [31:0] hilo_wdata = '0;
   logic        stall_o;
   logic        done_o;
   logic        mlu_start;
   logic        mlu_sign;
   logic [31:0] mlu_op1;
   logic [31:0] mlu_op2;
   logic [63:0] mlu_result;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] m_hilo = '0;

   mul_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .flush(flush), .hilo_we(hilo_we),
      .hilo_wdata(hilo_wdata),
      .stall_o(stall_o), .done_o(done_o),
      .mlu_start(mlu_start), .mlu_sign(mlu_sign),
      .mlu_op1(mlu_op1), .mlu_op2(mlu_op2),
      .mlu_result(mlu_result),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mult(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic sgn);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (sgn) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Array multiplier stand-in: garbage unless enabled
   assign mlu_result = mlu_start ? mult(mlu_op1, mlu_op2, mlu_sign)
                                 : 64'hA5A5_5A5A_0F0F_F0F0;

   function automatic logic [63:0] model(input logic [63:0] hl,
                                         input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      p = mult(a, b, ~op[0]);
`ifdef MUL_ACC_EN
      if (op[2:1] == 2'b01) return hl + p;
      if (op[2:1] == 2'b10) return hl - p;
`endif
      return p;
   endfunction

   task automatic hilo_write(input logic [1:0] we, input logic [31:0] d);
      hilo_we = we;
      hilo_wdata = d;
      @(negedge clk);
      hilo_we = 2'b00;
      if (we[1]) m_hilo[63:32] = d;
      if (we[0]) m_hilo[31:0] = d;
      n_tests++;
      if ({hi_o, lo_o} !== m_hilo) begin
         n_fail++;
         $display("FAIL hilo_write we=%b got=%h exp=%h", we, {hi_o, lo_o}, m_hilo);
      end
   endtask

   // Full multiply from IDLE; optional MTHI/MTLO in the WB cycle
   task automatic do_mul(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] wb_we);
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      #1;
      n_tests++;
      if (stall_o !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_stall got=%b exp=1", stall_o);
      end
      @(negedge clk);
      req_a = $urandom;
      req_b = $urandom;
      for (int i = 0; i < MUL_LAT; i++) begin
         n_tests++;
         if (stall_o !== 1'b1 || mlu_start !== 1'b1 || done_o !== 1'b0 ||
             mlu_sign !== ~op[0] || mlu_op1 !== a || mlu_op2 !== b) begin
            n_fail++;
            $display("FAIL calc%0d got st=%b go=%b dn=%b sg=%b o1=%h o2=%h exp 1 1 0 %b %h %h",
                     i, stall_o, mlu_start, done_o, mlu_sign, mlu_op1, mlu_op2, ~op[0], a, b);
         end
         @(negedge clk);
      end
      n_tests++;
      if (stall_o !== 1'b0 || done_o !== 1'b1 || mlu_start !== 1'b0) begin
         n_fail++;
         $display("FAIL wb_cycle got st=%b dn=%b go=%b exp 0 1 0", stall_o, done_o, mlu_start);
      end
      req_valid = 1'b0;
      hilo_we = wb_we;
      hilo_wdata = $urandom;
      m_hilo = model(m_hilo, op, a, b);
      @(negedge clk);
      hilo_we = 2'b00;
      n_tests++;
      if ({hi_o, lo_o} !== m_hilo || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mul op=%b a=%h b=%h got=%h dn=%b exp=%h dn=0",
                  op, a, b, {hi_o, lo_o}, done_o, m_hilo);
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (hi_o !== 32'h0 || lo_o !== 32'h0 || done_o !== 1'b0 ||
          mlu_start !== 1'b0 || stall_o !== 1'b0 || mlu_op1 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset got hi=%h lo=%h dn=%b go=%b st=%b exp all 0",
                  hi_o, lo_o, done_o, mlu_start, stall_o);
      end
      resetn = 1'b1;
      m_hilo = '0;
      @(negedge clk);
   endtask

   task automatic test_directed;
      do_mul(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 2'b00);
      n_tests++;
      if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         n_fail++;
         $display("FAIL plan_mult got=%h exp=ffffffff_fffffffa", {hi_o, lo_o});
      end
      do_mul(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
      n_tests++;
      if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++;
         $display("FAIL plan_multu got=%h exp=fffffffe_00000001", {hi_o, lo_o});
      end
      hilo_write(2'b10, 32'h0);
      hilo_write(2'b01, 32'hFFFF_FFFF);
      do_mul(3'b011, 32'h1, 32'h1, 2'b00);
      n_tests++;
`ifdef MUL_ACC_EN
      if ({hi_o, lo_o} !== 64'h0000_0001_0000_0000) begin
`else
      if ({hi_o, lo_o} !== 64'h0000_0000_0000_0001) begin
`endif
         n_fail++;
         $display("FAIL plan_maddu got=%h", {hi_o, lo_o});
      end
      hilo_write(2'b11, 32'h0);
      do_mul(3'b100, 32'h1, 32'h1, 2'b00);
      n_tests++;
`ifdef MUL_ACC_EN
      if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
`else
      if ({hi_o, lo_o} !== 64'h0000_0000_0000_0001) begin
`endif
         n_fail++;
         $display("FAIL plan_msub got=%h", {hi_o, lo_o});
      end
   endtask

   task automatic test_random;
      logic [31:0] a;
      logic [31:0] b;
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFFF;
         if ($urandom_range(0, 4) == 0)
            hilo_write(2'($urandom_range(1, 3)), $urandom);
         else
            do_mul(3'($urandom_range(0, 7)), a, b, 2'b00);
      end
   endtask

   task automatic test_flush;
      logic [31:0] d;
      hilo_write(2'b11, $urandom);
      req_valid = 1'b1;
      req_op = 3'b000;
      req_a = $urandom;
      req_b = $urandom;
      flush = 1'b1;
      #1;
      n_tests++;
      if (stall_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle_stall got=%b exp=0", stall_o);
      end
      @(negedge clk);
      n_tests++;
      if (mlu_start !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle_accept go=%b exp=0", mlu_start);
      end
      flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (mlu_start !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0 ||
             {hi_o, lo_o} !== m_hilo) begin
            n_fail++;
            $display("FAIL flush_calc%0d go=%b st=%b dn=%b hl=%h exp 0 0 0 %h",
                     i, mlu_start, stall_o, done_o, {hi_o, lo_o}, m_hilo);
         end
         @(negedge clk);
      end
      req_valid = 1'b1;
      req_op = 3'b001;
      req_a = $urandom;
      req_b = $urandom;
      repeat (MUL_LAT + 1) @(negedge clk);
      req_valid = 1'b0;
      flush = 1'b1;
      d = $urandom;
      hilo_we = 2'b01;
      hilo_wdata = d;
      #1;
      n_tests++;
      if (done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_wb_done got=%b exp=0", done_o);
      end
      @(negedge clk);
      flush = 1'b0;
      hilo_we = 2'b00;
      m_hilo[31:0] = d;
      n_tests++;
      if ({hi_o, lo_o} !== m_hilo) begin
         n_fail++;
         $display("FAIL flush_wb_hilo got=%h exp=%h", {hi_o, lo_o}, m_hilo);
      end
   endtask

   task automatic test_reset_mid;
      hilo_write(2'b10, 32'h1234_5678);
      req_valid = 1'b1;
      req_op = 3'b000;
      req_a = 32'h0000_0007;
      req_b = 32'h0000_0009;
      @(negedge clk);
      req_valid = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      m_hilo = '0;
      n_tests++;
      if (hi_o !== 32'h0 || lo_o !== 32'h0 || stall_o !== 1'b0 ||
          done_o !== 1'b0 || mlu_start !== 1'b0 ||
          mlu_op1 !== 32'h0 || mlu_op2 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid hi=%h lo=%h st=%b dn=%b go=%b o1=%h o2=%h exp all 0",
                  hi_o, lo_o, stall_o, done_o, mlu_start, mlu_op1, mlu_op2);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++;
         if (done_o !== 1'b0 || {hi_o, lo_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid_after%0d dn=%b hl=%h exp 0 0", i, done_o, {hi_o, lo_o});
         end
      end
   endtask

   task automatic test_collide;
      hilo_write(2'b11, $urandom);
      do_mul(3'b000, $urandom, $urandom, 2'b10);
      do_mul(3'b001, $urandom, $urandom, 2'b01);
      do_mul(3'($urandom_range(0, 7)), $urandom, $urandom, 2'b11);
   endtask

   task automatic test_back_to_back;
      for (int n = 0; n < 8; n++)
         do_mul(3'($urandom_range(0, 7)), $urandom, $urandom, 2'b00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset;
      test_directed;
      test_random;
      test_flush;
      test_reset_mid;
      test_collide;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
Multi-cycle sequencer between the EX stage and the combinational 32x32 array multiplier (mul_start/mul_sign/op1/op2 -> 64-bit result).
- Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU requests and latches operands.
- Holds the multiplier enabled for a fixed settle window, then captures the product.
- Owns the HI/LO register pair and stalls the pipeline while busy.

Parameters:
MUL_LAT, 2, cycles the multiplier is held enabled before its result is sampled (legal 1..4)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous reset, active-low
req_valid  in  1  EX stage holds a multiply instruction
req_op  in  3  bit0=unsigned; bits[2:1]: 00 overwrite, 01 accumulate-add, 10 accumulate-sub, 11 reserved (treated as 00)
req_a  in  32  rs operand
req_b  in  32  rt operand
flush  in  1  kill in-flight instruction (exception/branch flush)
hilo_we  in  2  bit1 writes HI, bit0 writes LO (MTHI/MTLO from WB stage)
hilo_wdata  in  32  MTHI/MTLO data
stall_o  out  1  hold IF..EX
done_o  out  1  one-cycle pulse on HI/LO commit
mlu_start  out  1  multiplier enable
mlu_sign  out  1  signed-multiply select
mlu_op1  out  32  multiplier operand 1
mlu_op2  out  32  multiplier operand 2
mlu_result  in  64  multiplier product
hi_o  out  32  HI register
lo_o  out  32  LO register

Behaviour:
- Reset (resetn low at clk edge, any state):
  - state=IDLE, counter=0, operand/op latches=0, hi_o=lo_o=0.
  - done_o=0, mlu_start=0.
  - Reset mid-operation aborts without a HI/LO write.
- States:
  - IDLE:
    - stall_o = req_valid & ~flush (combinational).
    - On the edge with req_valid & ~flush: latch req_a/req_b/req_op, set cnt=MUL_LAT-1, go CALC.
  - CALC:
    - mlu_start=1, stall_o=1.
    - cnt>0: decrement.
    - cnt==0: capture mlu_result into 64-bit prod register, go WB.
  - WB:
    - stall_o=0, mlu_start=0, done_o=1.
    - At the edge, {hi,lo} <= prod, {hi,lo}+prod or {hi,lo}-prod per op (64-bit, modulo 2^64, carry/borrow discarded).
    - Then go IDLE.
    - req_valid is ignored in WB; the same instruction leaves EX at this edge.
- Latency:
  - Accept edge T; HI/LO valid after edge T+MUL_LAT+1.
  - stall_o high for MUL_LAT+1 cycles; back-to-back multiplies cost MUL_LAT+2 cycles each.
- Multiplier driving:
  - mlu_op1/op2 are driven from the latches in all states.
  - mlu_sign = ~latched op bit0.
  - mlu_start only in CALC.
- Flush:
  - IDLE: no accept.
  - CALC: next state IDLE, no capture, no HI/LO write.
  - WB: HI/LO write and done_o suppressed; go IDLE.
- hilo_we:
  - Writes the selected half at the edge in any state.
  - If coincident with a WB commit, the commit wins for both halves (the multiply is the younger instruction).
- hi_o/lo_o are register outputs only; no bypass of the in-flight product.

Optional Feature:
MUL_ACC_EN
- Defined: accumulate-add/sub ops behave as described.
- Undefined: bits[2:1] are ignored, every op overwrites {hi,lo} with the product (signedness still from bit0), and the 64-bit adder/subtractor is not built.

Test Plan:
- MUL_LAT=2, op=000, a=0xFFFFFFFE, b=0x00000003 -> stall_o high 3 cycles, done_o pulse in 4th cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- op=001, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; mlu_sign=0 throughout CALC.
- hilo_we=01, wdata=0xFFFFFFFF (hi=0); then op=011, a=b=1 -> hi=0x00000001, lo=0x00000000 (with MUL_ACC_EN; without: hi=0, lo=1).
- hi=lo=0, op=100, a=b=1 -> hi=lo=0xFFFFFFFF.
- flush asserted in 2nd CALC cycle -> IDLE next cycle, mlu_start low, done_o never pulses, HI/LO unchanged.
- resetn low during CALC with hi=0x12345678 -> next cycle all outputs 0, state IDLE; hilo_we=10 coincident with WB commit -> commit value retained.
